// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-access stage.
// Byte-enable lane codes, SC result values and the bus-error fill word.
package mem_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } fsm_state_t;

    localparam logic [3:0] BE_B0   = 4'b0001;
    localparam logic [3:0] BE_B1   = 4'b0010;
    localparam logic [3:0] BE_B2   = 4'b0100;
    localparam logic [3:0] BE_B3   = 4'b1000;
    localparam logic [3:0] BE_HLO  = 4'b0011;
    localparam logic [3:0] BE_HHI  = 4'b1100;
    localparam logic [3:0] BE_WORD = 4'b1111;

    localparam logic [31:0] SC_PASS      = 32'd1;
    localparam logic [31:0] SC_FAIL      = 32'd0;
    localparam logic [31:0] BUS_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: right-justifies load data and
// replicates store data across the lanes selected by the byte enables.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [3:0]  be_i,
    input  logic [31:0] rdata_i,
    input  logic [31:0] r2_i,
    output logic [31:0] load_o,
    output logic [31:0] store_o
);

    always_comb begin
        load_o = rdata_i;
        case (be_i)
            BE_B0:   load_o = {24'h0, rdata_i[7:0]};
            BE_B1:   load_o = {24'h0, rdata_i[15:8]};
            BE_B2:   load_o = {24'h0, rdata_i[23:16]};
            BE_B3:   load_o = {24'h0, rdata_i[31:24]};
            BE_HLO:  load_o = {16'h0, rdata_i[15:0]};
            BE_HHI:  load_o = {16'h0, rdata_i[31:16]};
            default: load_o = rdata_i;
        endcase
    end

    // Memory picks the lane from mem_be, so every lane carries the value.
    always_comb begin
        store_o = r2_i;
        case (be_i)
            BE_B0, BE_B1, BE_B2, BE_B3: store_o = {4{r2_i[7:0]}};
            BE_HLO, BE_HHI:             store_o = {2{r2_i[15:0]}};
            default:                    store_o = r2_i;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// s4 memory stage: data-memory handshake, LL/SC link register, s5 register.
// Optional ack timeout with bus_err_o when MEM_TIMEOUT_EN is defined.
//   state | meaning
//   IDLE  | no access outstanding; a new request may issue this cycle
//   WAIT  | request issued, waiting for mem_ack (upstream frozen)
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int BITS      = 32,
    parameter int REG_WORDS = 32,
    parameter int ADDR_LEFT = $clog2(REG_WORDS) - 1
`ifdef MEM_TIMEOUT_EN
    ,
    parameter int TIMEOUT   = 255
`endif
)(
    input  logic                 clk,
    input  logic                 rst_,
    input  logic [BITS-1:0]      alu_out_s4,
    input  logic                 atomic_s4,
    input  logic                 sel_mem_s4,
    input  logic                 check_link_s4,
    input  logic                 mem_rw_s4,
    input  logic                 rw_s4,
    input  logic [ADDR_LEFT:0]   waddr_s4,
    input  logic                 load_link_s4,
    input  logic [BITS-1:0]      r2_data_s4,
    input  logic [3:0]           byte_en_s4,
    input  logic                 halt_s4,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [BITS-1:0]      mem_addr,
    output logic [BITS-1:0]      mem_wdata,
    output logic [3:0]           mem_be,
    output logic                 mem_lock,
    input  logic                 mem_ack,
    input  logic [BITS-1:0]      mem_rdata,
    output logic                 stall_o,
    output logic [BITS-1:0]      wdata_s5,
    output logic [ADDR_LEFT:0]   waddr_s5,
    output logic                 rw_s5,
    output logic                 halt_s5,
    output logic                 link_valid_o
`ifdef MEM_TIMEOUT_EN
    ,
    output logic                 bus_err_o
`endif
);

    fsm_state_t      state_q, state_d;
    logic            link_valid_q, link_valid_d;
    logic [BITS-3:0] link_addr_q, link_addr_d;
    logic [BITS-1:0] load_data, store_data, wdata_d;
    logic            sc_fail, done, tmo_hit;

    mem_lane_align u_align (
        .be_i    (byte_en_s4),
        .rdata_i (mem_rdata),
        .r2_i    (r2_data_s4),
        .load_o  (load_data),
        .store_o (store_data)
    );

    assign sc_fail = check_link_s4 & ~(link_valid_q & (link_addr_q == alu_out_s4[BITS-1:2]));

`ifdef MEM_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_cnt_q;
    logic             bus_err_q;

    // Reloaded outside WAIT; reaching zero means TIMEOUT cycles already waited.
    assign tmo_hit = (state_q == WAIT) & ~mem_ack & (tmo_cnt_q == '0);

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            tmo_cnt_q <= TMO_W'(TIMEOUT);
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= tmo_hit;
            if (state_q == WAIT)
                tmo_cnt_q <= tmo_cnt_q - 1'b1;
            else
                tmo_cnt_q <= TMO_W'(TIMEOUT);
        end
    end

    assign bus_err_o = bus_err_q;
`else
    assign tmo_hit = 1'b0;
`endif

    // Reset gates the combinational outputs so an abandoned access vanishes at once.
    assign stall_o   = rst_ & sel_mem_s4 & ~sc_fail & ~mem_ack & ~tmo_hit;
    assign mem_req   = rst_ & ~tmo_hit & ((state_q == WAIT) | (sel_mem_s4 & ~sc_fail));
    assign mem_we    = ~mem_rw_s4;
    assign mem_addr  = alu_out_s4;
    assign mem_wdata = store_data;
    assign mem_be    = byte_en_s4;
    assign mem_lock  = atomic_s4 & mem_req;
    assign done      = sel_mem_s4 & ~stall_o;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (mem_req & ~mem_ack) state_d = WAIT;
            WAIT: if (mem_ack | tmo_hit)  state_d = IDLE;
        endcase
    end

    always_comb begin
        link_valid_d = link_valid_q;
        link_addr_d  = link_addr_q;
        if (done) begin
            if (check_link_s4)
                link_valid_d = 1'b0;
            else if (~mem_rw_s4 & (link_addr_q == alu_out_s4[BITS-1:2]))
                link_valid_d = 1'b0;
            if (mem_rw_s4 & ~load_link_s4 & ~tmo_hit) begin
                link_valid_d = 1'b1;
                link_addr_d  = alu_out_s4[BITS-1:2];
            end
        end
    end

    always_comb begin
        wdata_d = alu_out_s4;
        if (sel_mem_s4) begin
            if (tmo_hit)
                wdata_d = BUS_ERR_DATA;
            else if (check_link_s4)
                wdata_d = sc_fail ? SC_FAIL : SC_PASS;
            else
                wdata_d = load_data;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q      <= IDLE;
            link_valid_q <= 1'b0;
            link_addr_q  <= '0;
        end else begin
            state_q      <= state_d;
            link_valid_q <= link_valid_d;
            link_addr_q  <= link_addr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            wdata_s5 <= '0;
            waddr_s5 <= '0;
            rw_s5    <= 1'b1;
            halt_s5  <= 1'b0;
        end else if (stall_o) begin
            rw_s5    <= 1'b1;
            halt_s5  <= 1'b0;
        end else begin
            wdata_s5 <= wdata_d;
            waddr_s5 <= waddr_s4;
            rw_s5    <= rw_s4;
            halt_s5  <= halt_s4;
        end
    end

    assign link_valid_o = link_valid_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed vector table, hand-written reset
// sequence, and random ops checked against an op-level reference model.
module tb_mem_access_stage;

    localparam int K_NON = 0;
    localparam int K_LD  = 1;
    localparam int K_LL  = 2;
    localparam int K_ST  = 3;
    localparam int K_SC  = 4;

    logic        clk = 1'b0;
    logic        rst_;
    logic [31:0] alu_out_s4, r2_data_s4, mem_rdata;
    logic        atomic_s4, sel_mem_s4, check_link_s4, mem_rw_s4, rw_s4, load_link_s4, halt_s4;
    logic [4:0]  waddr_s4;
    logic [3:0]  byte_en_s4;
    logic        mem_ack;
    logic        mem_req, mem_we, mem_lock, stall_o, rw_s5, halt_s5, link_valid_o;
    logic [31:0] mem_addr, mem_wdata, wdata_s5;
    logic [3:0]  mem_be;
    logic [4:0]  waddr_s5;

    always #5 clk = ~clk;

    mem_access_stage dut (
        .clk(clk), .rst_(rst_),
        .alu_out_s4(alu_out_s4), .atomic_s4(atomic_s4), .sel_mem_s4(sel_mem_s4),
        .check_link_s4(check_link_s4), .mem_rw_s4(mem_rw_s4), .rw_s4(rw_s4),
        .waddr_s4(waddr_s4), .load_link_s4(load_link_s4), .r2_data_s4(r2_data_s4),
        .byte_en_s4(byte_en_s4), .halt_s4(halt_s4),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_lock(mem_lock), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .stall_o(stall_o), .wdata_s5(wdata_s5), .waddr_s5(waddr_s5), .rw_s5(rw_s5),
        .halt_s5(halt_s5), .link_valid_o(link_valid_o)
    );

    typedef struct {
        int          kind;
        logic [31:0] alu, r2, rdata;
        logic        sel, atomic, chk, rw_mem, rw, ll, halt;
        logic [4:0]  waddr;
        logic [3:0]  be;
        int          delay;
    } op_t;

    typedef struct {
        logic        req, we, lock, rw, halt, lv;
        logic [31:0] bus, addr, wdata;
        logic [3:0]  be;
        logic [4:0]  waddr;
        int          stalls;
        logic        bubble_ok, hold_ok;
    } obs_t;

    typedef struct {
        op_t         op;
        logic [31:0] ew, eb;
        logic        er;
        int          es;
        logic        elv;
        bit          cw, cb;
    } vec_t;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic op_t mk(int kind, logic [31:0] alu, logic [31:0] r2, logic [3:0] be,
                               logic [31:0] rdata, int delay, logic [4:0] waddr);
        op_t o;
        o.kind   = kind;
        o.alu    = alu;
        o.r2     = r2;
        o.be     = be;
        o.rdata  = rdata;
        o.delay  = delay;
        o.waddr  = waddr;
        o.sel    = (kind != K_NON);
        o.chk    = (kind == K_SC);
        o.ll     = (kind == K_LL) ? 1'b0 : 1'b1;
        o.rw_mem = (kind == K_ST || kind == K_SC) ? 1'b0 : 1'b1;
        o.rw     = (kind == K_ST) ? 1'b1 : 1'b0;
        o.atomic = (kind == K_LL || kind == K_SC);
        o.halt   = 1'b0;
        return o;
    endfunction

    function automatic vec_t mkv(op_t op, logic [31:0] ew, logic [31:0] eb, logic er, int es,
                                 logic elv, bit cw, bit cb);
        vec_t v;
        v.op = op; v.ew = ew; v.eb = eb; v.er = er; v.es = es; v.elv = elv; v.cw = cw; v.cb = cb;
        return v;
    endfunction

    // Reference: expected load result from the lane the byte enables name.
    function automatic logic [31:0] ref_align(logic [3:0] be, logic [31:0] d);
        for (int i = 0; i < 4; i++)
            if (be == (4'b0001 << i)) return (d >> (8 * i)) & 32'h0000_00FF;
        if (be == 4'b0011) return d & 32'h0000_FFFF;
        if (be == 4'b1100) return d >> 16;
        return d;
    endfunction

    function automatic logic [31:0] ref_repl(logic [3:0] be, logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[7:0];
        h = d[15:0];
        if ($countones(be) == 1) return {b, b, b, b};
        if (be == 4'b0011 || be == 4'b1100) return {h, h};
        return d;
    endfunction

    task automatic drive_idle();
        alu_out_s4 = 32'h0; r2_data_s4 = 32'h0; atomic_s4 = 1'b0; sel_mem_s4 = 1'b0;
        check_link_s4 = 1'b0; mem_rw_s4 = 1'b1; rw_s4 = 1'b1; load_link_s4 = 1'b1;
        halt_s4 = 1'b0; waddr_s4 = 5'd0; byte_en_s4 = 4'h0; mem_ack = 1'b0;
    endtask

    task automatic drive(input op_t o);
        alu_out_s4 = o.alu; r2_data_s4 = o.r2; atomic_s4 = o.atomic; sel_mem_s4 = o.sel;
        check_link_s4 = o.chk; mem_rw_s4 = o.rw_mem; rw_s4 = o.rw; load_link_s4 = o.ll;
        halt_s4 = o.halt; waddr_s4 = o.waddr; byte_en_s4 = o.be;
    endtask

    // Starts 1 time unit after a rising edge; ends at the same phase one edge after completion.
    task automatic run_op(input op_t op, output obs_t o);
        int cyc;
        drive(op);
        mem_rdata = op.rdata;
        mem_ack = (op.delay == 0);
        #3;
        o.req = mem_req; o.we = mem_we; o.lock = mem_lock; o.bus = mem_wdata;
        o.addr = mem_addr; o.be = mem_be;
        o.stalls = 0; o.bubble_ok = 1'b1; o.hold_ok = 1'b1;
        cyc = 0;
        while (stall_o === 1'b1 && cyc < 40) begin
            o.stalls++;
            @(posedge clk); #1;
            if (rw_s5 !== 1'b1 || halt_s5 !== 1'b0) o.bubble_ok = 1'b0;
            cyc++;
            mem_ack = (cyc == op.delay);
            #3;
            if (mem_req !== 1'b1 || mem_wdata !== o.bus || mem_addr !== o.addr ||
                mem_be !== o.be || mem_we !== o.we) o.hold_ok = 1'b0;
        end
        if (cyc >= 40) begin
            total++;
            bad++;
            $display("FAIL ack_wait_bound: stall still high after %0d cycles, required release", cyc);
        end
        @(posedge clk); #1;
        o.wdata = wdata_s5; o.waddr = waddr_s5; o.rw = rw_s5; o.halt = halt_s5; o.lv = link_valid_o;
        drive_idle();
    endtask

    task automatic check_op(input string tag, input op_t op, input obs_t o, input logic er,
                            input int es, input logic [31:0] ew, input bit cw,
                            input logic [31:0] eb, input bit cb, input logic elv);
        chk({tag, ".req"}, o.req, er);
        chk({tag, ".stalls"}, o.stalls, es);
        chk({tag, ".bubble"}, o.bubble_ok, 1'b1);
        if (es > 0) chk({tag, ".hold"}, o.hold_ok, 1'b1);
        chk({tag, ".addr"}, o.addr, op.alu);
        chk({tag, ".be"}, o.be, op.be);
        chk({tag, ".we"}, o.we, !op.rw_mem);
        chk({tag, ".lock"}, o.lock, op.atomic & er);
        if (cw) chk({tag, ".wdata"}, o.wdata, ew);
        if (cb) chk({tag, ".bus"}, o.bus, eb);
        chk({tag, ".waddr"}, o.waddr, op.waddr);
        chk({tag, ".rw"}, o.rw, op.rw);
        chk({tag, ".halt"}, o.halt, op.halt);
        chk({tag, ".lv"}, o.lv, elv);
    endtask

    vec_t        tbl[16];
    op_t         op;
    obs_t        ob;
    int          kind;
    logic [31:0] a, ew;
    logic        er, lv_m;
    logic [29:0] la_m;
    logic [31:0] bases[3];

    initial begin
        tbl[0]  = mkv(mk(K_NON, 32'h1234_5678, 32'h0, 4'h0, 32'h0, -1, 5'd5), 32'h1234_5678, 32'h0, 0, 0, 0, 1, 0);
        tbl[0].op.halt = 1'b1;
        tbl[1]  = mkv(mk(K_LD, 32'h0000_0040, 32'h0, 4'b0100, 32'hAABB_CCDD, 3, 5'd1), 32'h0000_00BB, 32'h0, 1, 3, 0, 1, 0);
        tbl[2]  = mkv(mk(K_ST, 32'h0000_0401, 32'h0000_0042, 4'b0010, 32'h0, 1, 5'd2), 32'h0, 32'h4242_4242, 1, 1, 0, 0, 1);
        tbl[3]  = mkv(mk(K_ST, 32'h0000_0402, 32'h0000_BEEF, 4'b1100, 32'h0, 0, 5'd3), 32'h0, 32'hBEEF_BEEF, 1, 0, 0, 0, 1);
        tbl[4]  = mkv(mk(K_ST, 32'h0000_0404, 32'hCAFE_F00D, 4'b1111, 32'h0, 2, 5'd4), 32'h0, 32'hCAFE_F00D, 1, 2, 0, 0, 1);
        tbl[5]  = mkv(mk(K_LD, 32'h0000_0044, 32'h0, 4'b0001, 32'h1122_3344, 0, 5'd6), 32'h0000_0044, 32'h0, 1, 0, 0, 1, 0);
        tbl[6]  = mkv(mk(K_LD, 32'h0000_0047, 32'h0, 4'b1000, 32'h1122_3344, 1, 5'd7), 32'h0000_0011, 32'h0, 1, 1, 0, 1, 0);
        tbl[7]  = mkv(mk(K_LD, 32'h0000_0048, 32'h0, 4'b0011, 32'h1122_3344, 0, 5'd8), 32'h0000_3344, 32'h0, 1, 0, 0, 1, 0);
        tbl[8]  = mkv(mk(K_LD, 32'h0000_004A, 32'h0, 4'b1100, 32'h1122_3344, 2, 5'd9), 32'h0000_1122, 32'h0, 1, 2, 0, 1, 0);
        tbl[9]  = mkv(mk(K_LD, 32'h0000_004C, 32'h0, 4'b0101, 32'h1122_3344, 0, 5'd10), 32'h1122_3344, 32'h0, 1, 0, 0, 1, 0);
        tbl[10] = mkv(mk(K_SC, 32'h0000_0300, 32'h0000_0009, 4'b1111, 32'h0, -1, 5'd11), 32'h0, 32'h0, 0, 0, 0, 1, 0);
        tbl[11] = mkv(mk(K_LL, 32'h0000_0100, 32'h0, 4'b1111, 32'h0000_0055, 2, 5'd12), 32'h0000_0055, 32'h0, 1, 2, 1, 1, 0);
        tbl[12] = mkv(mk(K_SC, 32'h0000_0100, 32'h0000_00A5, 4'b1111, 32'h0, 1, 5'd13), 32'h1, 32'h0000_00A5, 1, 1, 0, 1, 1);
        tbl[13] = mkv(mk(K_LL, 32'h0000_0100, 32'h0, 4'b1111, 32'h0000_0066, 0, 5'd14), 32'h0000_0066, 32'h0, 1, 0, 1, 1, 0);
        tbl[14] = mkv(mk(K_ST, 32'h0000_0100, 32'h0000_0123, 4'b1111, 32'h0, 0, 5'd15), 32'h0, 32'h0000_0123, 1, 0, 0, 0, 1);
        tbl[15] = mkv(mk(K_SC, 32'h0000_0100, 32'h0000_0077, 4'b1111, 32'h0, -1, 5'd16), 32'h0, 32'h0, 0, 0, 0, 1, 0);
        bases[0] = 32'h0000_0100; bases[1] = 32'h0000_0104; bases[2] = 32'h0000_0200;

        rst_ = 1'b0;
        drive_idle();
        mem_rdata = 32'h0;
        sel_mem_s4 = 1'b1;
        #12;
        chk("reset.wdata", wdata_s5, 32'h0);
        chk("reset.waddr", waddr_s5, 5'd0);
        chk("reset.rw", rw_s5, 1'b1);
        chk("reset.halt", halt_s5, 1'b0);
        chk("reset.lv", link_valid_o, 1'b0);
        chk("reset.req", mem_req, 1'b0);
        chk("reset.stall", stall_o, 1'b0);
        drive_idle();
        rst_ = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) begin
            run_op(tbl[i].op, ob);
            check_op($sformatf("vec%0d", i), tbl[i].op, ob, tbl[i].er, tbl[i].es, tbl[i].ew,
                     tbl[i].cw, tbl[i].eb, tbl[i].cb, tbl[i].elv);
        end

        // Reset while an access is outstanding.
        run_op(mk(K_LL, 32'h0000_0100, 32'h0, 4'hF, 32'h77, 1, 5'd3), ob);
        chk("rstwait.lv_before", ob.lv, 1'b1);
        op = mk(K_LD, 32'h0000_0200, 32'h0, 4'hF, 32'h99, -1, 5'd4);
        drive(op);
        mem_ack = 1'b0;
        #3;
        chk("rstwait.req_issue", mem_req, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #3;
        chk("rstwait.stall_in_wait", stall_o, 1'b1);
        rst_ = 1'b0;
        #1;
        chk("rstwait.req_drop", mem_req, 1'b0);
        chk("rstwait.stall_drop", stall_o, 1'b0);
        chk("rstwait.rw", rw_s5, 1'b1);
        chk("rstwait.lv", link_valid_o, 1'b0);
        #2;
        drive_idle();
        rst_ = 1'b1;
        #1;
        chk("rstwait.idle_req", mem_req, 1'b0);
        @(posedge clk); #1;
        op = mk(K_LD, 32'h0000_0202, 32'h0, 4'b1100, 32'hFEDC_BA98, 1, 5'd9);
        run_op(op, ob);
        check_op("rstwait.after", op, ob, 1'b1, 1, 32'h0000_FEDC, 1'b1, 32'h0, 1'b0, 1'b0);

        lv_m = 1'b0;
        la_m = 30'h0;
        for (int n = 0; n < 150; n++) begin
            kind = int'($urandom_range(0, 4));
            a = bases[$urandom_range(0, 2)] | 32'($urandom_range(0, 3));
            if (kind == K_NON) a = $urandom;
            op = mk(kind, a, $urandom, 4'($urandom_range(0, 15)), $urandom, -1, 5'($urandom_range(0, 31)));
            op.halt = 1'($urandom_range(0, 1));
            er = (kind != K_NON) && !(kind == K_SC && !(lv_m && la_m == a[31:2]));
            if (er) op.delay = int'($urandom_range(0, 3));
            run_op(op, ob);
            if (kind == K_NON)      ew = a;
            else if (kind == K_SC)  ew = er ? 32'h1 : 32'h0;
            else                    ew = ref_align(op.be, op.rdata);
            if (kind == K_LL) begin
                lv_m = 1'b1;
                la_m = a[31:2];
            end else if (kind == K_SC) begin
                lv_m = 1'b0;
            end else if (kind == K_ST && la_m == a[31:2]) begin
                lv_m = 1'b0;
            end
            check_op($sformatf("rnd%0d", n), op, ob, er, er ? op.delay : 0, ew, kind != K_ST,
                     ref_repl(op.be, op.r2), (kind == K_ST) || (kind == K_SC && er), lv_m);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory stage (s4) logic. Consumes the EX/MEM pipeline register outputs and drives the data-memory req/ack handshake.
- Performs byte-lane alignment of load and store data and maintains the load-link/store-conditional link register.
- Registers results into the s5 (MEM/WB) stage outputs.
- Asserts stall_o to the hazard unit while a memory access is outstanding; the hazard unit freezes all upstream stages.

Parameters:
- BITS, 32, data word width; must be 32 (four byte lanes).
- REG_WORDS, 32, register file depth.
- ADDR_LEFT, $clog2(REG_WORDS)-1, MSB index of a register address.
- TIMEOUT, 255, maximum ack wait in cycles; used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- rst_  in  1  asynchronous active-low reset
- alu_out_s4  in  BITS  effective address, or ALU result for non-memory ops
- atomic_s4  in  1  1 = atomic access; drives mem_lock
- sel_mem_s4  in  1  1 = memory operation present in s4
- check_link_s4  in  1  1 = store-conditional
- mem_rw_s4  in  1  1 = read, 0 = write
- rw_s4  in  1  register write enable, active-low
- waddr_s4  in  ADDR_LEFT+1  destination register
- load_link_s4  in  1  0 = load-linked (active-low)
- r2_data_s4  in  BITS  store data
- byte_en_s4  in  4  byte-lane enables
- halt_s4  in  1  halt marker
- mem_req  out  1  memory request
- mem_we  out  1  1 = write
- mem_addr  out  BITS  equals alu_out_s4
- mem_wdata  out  BITS  lane-replicated store data
- mem_be  out  4  equals byte_en_s4
- mem_lock  out  1  equals atomic_s4 & mem_req
- mem_ack  in  1  access complete; read data valid this cycle
- mem_rdata  in  BITS  read data
- stall_o  out  1  freeze upstream stages
- wdata_s5  out  BITS  writeback data
- waddr_s5  out  ADDR_LEFT+1  writeback register
- rw_s5  out  1  writeback enable, active-low
- halt_s5  out  1  halt marker
- link_valid_o  out  1  link register valid (debug/visibility)

Behaviour:
- Reset (async, rst_ low):
  - FSM to IDLE; link_valid cleared; link_addr = 0.
  - wdata_s5 = 0, waddr_s5 = 0, rw_s5 = 1, halt_s5 = 0.
  - mem_req and stall_o forced 0 while rst_ is low. A reset during WAIT abandons the access immediately.
- FSM states: IDLE, WAIT.
  - IDLE: mem_req = sel_mem_s4 & ~sc_fail.
    - mem_ack in the same cycle completes the op in zero wait states.
    - mem_req without mem_ack moves to WAIT.
  - WAIT: mem_req held at 1. mem_addr, mem_wdata, mem_be and mem_we must stay stable (upstream is frozen).
    - mem_ack returns to IDLE.
- sc_fail = check_link_s4 & ~(link_valid & link_addr == alu_out_s4[BITS-1:2]). A failing SC issues no request and completes in one cycle.
- stall_o = sel_mem_s4 & ~sc_fail & ~mem_ack (combinational).
- s5 register updates on every clock edge:
  - stall_o = 1: insert a bubble (rw_s5 = 1, halt_s5 = 0; wdata_s5 and waddr_s5 hold).
  - stall_o = 0: capture waddr_s4, rw_s4, halt_s4, and wdata per the rules below.
  - Latency is 1 cycle plus memory wait cycles.
- wdata_s5 selection:
  - Non-memory op: alu_out_s4.
  - Load: aligned mem_rdata, zero-extended.
    - be 0001/0010/0100/1000 select bytes 0/1/2/3, right-justified.
    - be 0011/1100 select the low/high half.
    - be 1111, or any other pattern, returns the full word.
  - Ordinary store: wdata don't-care; waddr_s4 and rw_s4 are still captured.
  - SC success: 1. SC fail: 0.
- Store data replication onto mem_wdata:
  - Byte enables: {4{r2[7:0]}}.
  - Half enables: {2{r2[15:0]}}.
  - Otherwise r2 unchanged.
- mem_we = ~mem_rw_s4.
- Link register updates, applied when the op completes:
  - LL read sets link_valid and link_addr = alu_out_s4[BITS-1:2].
  - Any SC, pass or fail, clears link_valid.
  - An ordinary store whose word address matches link_addr clears link_valid.
  - If LL and a clear coincide, the LL wins (cannot occur within one op).

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - 8-bit (clog2(TIMEOUT+1)) counter runs while in WAIT.
  - When the count reaches TIMEOUT, the FSM forces IDLE, drops mem_req, and completes the op.
  - wdata_s5 = 32'hDEAD_BEEF, and bus_err_o (extra 1-bit output) pulses for one cycle.
- Undefined: no counter and no bus_err_o port; WAIT persists until mem_ack.

Decomposition:
- Shared package mem_pkg holds:
  - fsm_state_t enum {IDLE, WAIT}.
  - Byte-enable constants BE_B0..BE_B3, BE_HLO, BE_HHI, BE_WORD.
  - SC_PASS = 1 and SC_FAIL = 0.
  - BUS_ERR_DATA.
- One sub-module mem_lane_align: combinational load alignment and store replication from byte_en.

Test Plan:
- Non-memory op, alu_out = 32'h1234_5678, rw_s4 = 0, waddr = 5, no stall → next cycle wdata_s5 = 32'h1234_5678, waddr_s5 = 5, rw_s5 = 0.
- Load with be = 0100, mem_rdata = 32'hAABBCCDD, ack after 3 cycles → stall_o high for 3 cycles with bubbles in s5; then wdata_s5 = 32'h000000BB.
- Byte store, r2 = 32'h0000_0042, be = 0010 → mem_wdata = 32'h4242_4242, mem_we = 1, mem_be = 0010.
- LL at 0x100, then SC at 0x100 → SC issues a request; wdata_s5 = 1; link_valid_o = 0 afterwards.
- LL at 0x100, then store at 0x100, then SC at 0x100 → SC issues no mem_req, completes without stall, wdata_s5 = 0.
- rst_ pulsed low during WAIT → mem_req drops immediately; rw_s5 = 1, link_valid_o = 0; FSM restarts in IDLE.
